alu_seq: RTL

- Parametrised, registered successor to the processor's combinational 8-bit adder.
- Executes one of eight operations on two WIDTH-bit operands per transaction and returns a registered result plus status flags.
- Multiplication is multi-cycle (shift-add); all other operations complete in one cycle.
- Connects between the register-file read ports and the writeback mux, using a valid/ready handshake on both sides.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered multi-op ALU with valid/ready handshake on both sides
// Optional multi-cycle shift-add MUL for op 7 is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v
);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE, EXEC, MUL_RUN, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;

   logic [WIDTH-1:0]   res;
   logic               res_c, res_v;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH-1:0]   shamt;
   logic [2*WIDTH-1:0] shl_full, shr_full;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);

   always_comb begin
      res      = '0;
      res_c    = 1'b0;
      res_v    = 1'b0;
      sum_w    = '0;
      shamt    = b_q % WIDTH'(WIDTH);
      shl_full = {{WIDTH{1'b0}}, a_q} << shamt;
      shr_full = {a_q, {WIDTH{1'b0}}} >> shamt;
      case (op_q)
         3'd0: begin
            sum_w = {1'b0, a_q} + {1'b0, b_q};
            res   = sum_w[WIDTH-1:0];
            res_c = sum_w[WIDTH];
            res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'd1: begin
            sum_w = {1'b0, a_q} - {1'b0, b_q};
            res   = sum_w[WIDTH-1:0];
            res_c = ~sum_w[WIDTH];
            res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'd2: res = a_q & b_q;
         3'd3: res = a_q | b_q;
         3'd4: res = a_q ^ b_q;
         // Last bit shifted out lands just outside the result window; zero for shamt 0.
         3'd5: begin
            res   = shl_full[WIDTH-1:0];
            res_c = shl_full[WIDTH];
         end
         3'd6: begin
            res   = shr_full[2*WIDTH-1:WIDTH];
            res_c = shr_full[WIDTH-1];
         end
         default: res = '0;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // prod holds {partial sum, remaining multiplier bits}; one multiplier bit retires per cycle.
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     psum;

   assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         out    <= '0;
         out_hi <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         prod   <= '0;
         cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q  <= data1;
                  b_q  <= data2;
                  op_q <= op;
`ifdef ALU_SEQ_MUL_EN
                  if (op == 3'd7) begin
                     prod  <= {{WIDTH{1'b0}}, data2};
                     cnt   <= '0;
                     state <= MUL_RUN;
                  end else begin
                     state <= EXEC;
                  end
`else
                  state <= EXEC;
`endif
               end
            end
            EXEC: begin
               out    <= res;
               out_hi <= '0;
               flag_z <= (res == '0);
               flag_n <= res[WIDTH-1];
               flag_c <= res_c;
               flag_v <= res_v;
               state  <= HOLD;
            end
`ifdef ALU_SEQ_MUL_EN
            // Iterations use counts 0..WIDTH-1; count WIDTH is the product writeback cycle.
            MUL_RUN: begin
               if (cnt == CNT_W'(WIDTH)) begin
                  out    <= prod[WIDTH-1:0];
                  out_hi <= prod[2*WIDTH-1:WIDTH];
                  flag_z <= (prod[WIDTH-1:0] == '0);
                  flag_n <= prod[WIDTH-1];
                  flag_c <= (prod[2*WIDTH-1:WIDTH] != '0);
                  flag_v <= 1'b0;
                  state  <= HOLD;
               end else begin
                  prod <= {psum, prod[WIDTH-1:1]};
                  cnt  <= cnt + CNT_W'(1);
               end
            end
`endif
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
